// File: rtl/clock_period_meter_if.sv
// rtl/clock_period_meter_if.sv - result handshake bundle between the period meter and its consumer
//
// Signals:
//   Period      [WIDTH] Clk cycles between consecutive SigIn rising edges (0 on stall)
//   HighTime    [WIDTH] Clk cycles SigIn was sampled high within Period (0 on stall)
//   Stuck               result is a timeout rather than a measurement
//   StuckLevel          synchronized SigIn level when the timeout fired
//   ResultValid         result fields are valid
//   ResultReady         consumer accepts the result
// Modports:
//   master - the meter (drives the result, samples ResultReady)
//   slave  - the consumer (samples the result, drives ResultReady)
interface clock_period_meter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] Period;
    logic [WIDTH-1:0] HighTime;
    logic             Stuck;
    logic             StuckLevel;
    logic             ResultValid;
    logic             ResultReady;

    modport master (
        output Period,
        output HighTime,
        output Stuck,
        output StuckLevel,
        output ResultValid,
        input  ResultReady
    );

    modport slave (
        input  Period,
        input  HighTime,
        input  Stuck,
        input  StuckLevel,
        input  ResultValid,
        output ResultReady
    );
endinterface

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures period and high time of an asynchronous signal in Clk cycles
//
// Parameters:
//   WIDTH       counter / result width
//   SYNC_STAGES synchronizer depth on SigIn (must be at least 2)
//   TIMEOUT     Clk cycles without a rising edge before a stall is reported
//               (4 <= TIMEOUT <= 2^WIDTH-1)
// Ports:
//   Clk     in   system clock, all state on its rising edge
//   Reset   in   asynchronous active-low reset
//   Enable  in   measurement enable; low returns the block to IDLE
//   SigIn   in   signal under measurement, asynchronous to Clk
//   res     master modport of clock_period_meter_if carrying the result handshake
module clock_period_meter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 SigIn,
    clock_period_meter_if.master res
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_MEAS = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    // Synchronizer and edge detection
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   sync_w;
    logic                   rise_w;

    // Control and counters
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] high_q;
    logic [WIDTH-1:0] high_d;

    // Result registers
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] period_d;
    logic [WIDTH-1:0] hightime_q;
    logic [WIDTH-1:0] hightime_d;
    logic             stuck_q;
    logic             stuck_d;
    logic             level_q;
    logic             level_d;
    logic             valid_q;
    logic             valid_d;

    logic             timeout_w;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], SigIn};
    assign sync_w    = sync_q[SYNC_STAGES-1];
    assign rise_w    = sync_w & ~prev_q;
    assign timeout_w = (cnt_q == TIMEOUT_W);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_d     = high_q;
        period_d   = period_q;
        hightime_d = hightime_q;
        stuck_d    = stuck_q;
        level_d    = level_q;
        valid_d    = valid_q;

        if (!Enable) begin
            // Result fields are retained; only the handshake and the
            // in-progress measurement are abandoned.
            state_d = S_IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
            high_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    high_d  = '0;
                    state_d = S_ARM;
                end

                S_ARM: begin
                    if (rise_w) begin
                        // The rise cycle itself is the first high sample.
                        cnt_d   = ONE_W;
                        high_d  = ONE_W;
                        state_d = S_MEAS;
                    end else if (timeout_w) begin
                        period_d   = '0;
                        hightime_d = '0;
                        stuck_d    = 1'b1;
                        level_d    = sync_w;
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + ONE_W;
                    end
                end

                S_MEAS: begin
                    // Rise is checked before timeout so a period of exactly
                    // TIMEOUT cycles still yields a real measurement.
                    if (rise_w) begin
                        period_d   = cnt_q;
                        hightime_d = high_q;
                        stuck_d    = 1'b0;
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                    end else if (timeout_w) begin
                        period_d   = '0;
                        hightime_d = '0;
                        stuck_d    = 1'b1;
                        level_d    = sync_w;
                        valid_d    = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        cnt_d  = cnt_q + ONE_W;
                        high_d = high_q + WIDTH'(sync_w);
                    end
                end

                S_HOLD: begin
                    // Edges seen here are deliberately ignored; the next
                    // measurement starts from a fresh ARM.
                    if (valid_q && res.ResultReady) begin
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        high_d  = '0;
                        state_d = S_ARM;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            high_q     <= '0;
            period_q   <= '0;
            hightime_q <= '0;
            stuck_q    <= 1'b0;
            level_q    <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            prev_q     <= sync_w;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_q     <= high_d;
            period_q   <= period_d;
            hightime_q <= hightime_d;
            stuck_q    <= stuck_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
        end
    end

    assign res.Period      = period_q;
    assign res.HighTime    = hightime_q;
    assign res.Stuck       = stuck_q;
    assign res.StuckLevel  = level_q;
    assign res.ResultValid = valid_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - scoreboard bench for clock_period_meter
module tb_clock_period_meter;

    localparam int W  = 16;
    localparam int TO = 16;

    logic Clk    = 1'b0;
    logic Reset  = 1'b1;
    logic Enable = 1'b0;
    logic SigIn  = 1'b0;

    clock_period_meter_if #(.WIDTH(W)) bus ();

    clock_period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(2),
        .TIMEOUT    (TO)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Enable(Enable),
        .SigIn (SigIn),
        .res   (bus)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] high;
        logic         stuck;
        logic         level;
    } res_t;

    res_t sb[$];
    res_t last_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Waveform generator: periodic (gen_p cycles, gen_h high) or constant level.
    int gen_p     = 4;
    int gen_h     = 2;
    bit gen_const = 1'b0;
    bit gen_level = 1'b0;
    int phase     = 0;

    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (gen_const) begin
                SigIn = gen_level;
            end else begin
                if (phase >= gen_p) phase = 0;
                SigIn = (phase < gen_h);
                phase++;
                if (phase >= gen_p) phase = 0;
            end
        end
    end

    // Monitor / consumer: drives ResultReady and pops the scoreboard on handshakes.
    bit   mon_on    = 1'b0;
    bit   hold_mode = 1'b0;
    bit   pending   = 1'b0;
    bit   after_hs  = 1'b0;
    int   hold_wait = 0;
    res_t snap;

    initial begin
        res_t cur;
        res_t exp;
        bit   r;
        bus.ResultReady = 1'b0;
        forever begin
            @(negedge Clk);
            if (!mon_on) begin
                bus.ResultReady = 1'b0;
                pending  = 1'b0;
                after_hs = 1'b0;
            end else begin
                cur = {bus.Period, bus.HighTime, bus.Stuck, bus.StuckLevel};
                if (after_hs) begin
                    chk("valid_fall_after_handshake", 32'(bus.ResultValid), 0);
                    after_hs = 1'b0;
                end
                if (bus.ResultValid) begin
                    if (!pending) begin
                        pending   = 1'b1;
                        snap      = cur;
                        hold_wait = 0;
                    end else begin
                        chk("hold_stable", 32'(cur), 32'(snap));
                    end
                    hold_wait++;
                    r = hold_mode ? (hold_wait > 20) : ($urandom_range(0, 2) != 0);
                    if (r) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_result", 1, 0);
                        end else begin
                            exp = sb.pop_front();
                            chk("period",      32'(cur.period), 32'(exp.period));
                            chk("hightime",    32'(cur.high),   32'(exp.high));
                            chk("stuck",       32'(cur.stuck),  32'(exp.stuck));
                            if (exp.stuck)
                                chk("stuck_level", 32'(cur.level), 32'(exp.level));
                        end
                        pending  = 1'b0;
                        after_hs = 1'b1;
                    end
                    bus.ResultReady = r;
                end else begin
                    pending = 1'b0;
                    bus.ResultReady = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Reference: a steady waveform of period p / high h yields (p, h) for every
    // reported result; a constant level yields a stall tagged with that level.
    task automatic run_seg(input int p, input int h, input bit is_const, input bit lvl,
                           input int k, input bit hold);
        res_t e;
        int   guard;
        Enable    = 1'b0;
        gen_const = is_const;
        gen_level = lvl;
        gen_p     = p;
        gen_h     = h;
        hold_mode = hold;
        repeat (is_const ? 40 : 2 * p + 8) @(posedge Clk);
        #1;
        if (is_const) e = '{period: '0, high: '0, stuck: 1'b1, level: lvl};
        else          e = '{period: W'(p), high: W'(h), stuck: 1'b0, level: 1'b0};
        for (int i = 0; i < k; i++) sb.push_back(e);
        last_exp = e;
        Enable = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 2000) begin
            @(posedge Clk);
            guard++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
        @(posedge Clk);
        #1;
        Enable = 1'b0;
        hold_mode = 1'b0;
        repeat (3) @(posedge Clk);
    endtask

    initial begin
        int p;
        int h;
        int guard;

        #2 Reset = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("reset_valid",    32'(bus.ResultValid), 0);
        chk("reset_period",   32'(bus.Period),      0);
        chk("reset_hightime", 32'(bus.HighTime),    0);
        chk("reset_stuck",    32'(bus.Stuck),       0);
        @(posedge Clk);
        #1 Reset = 1'b1;
        mon_on = 1'b1;

        run_seg(4, 2, 1'b0, 1'b0, 3, 1'b0);
        run_seg(10, 3, 1'b0, 1'b0, 2, 1'b1);
        run_seg(0, 0, 1'b1, 1'b1, 2, 1'b0);
        run_seg(0, 0, 1'b1, 1'b0, 2, 1'b0);
        run_seg(16, 7, 1'b0, 1'b0, 2, 1'b0);

        // Enable dropped part-way through a measurement.
        gen_const = 1'b0;
        gen_p = 12;
        gen_h = 5;
        repeat (30) @(posedge Clk);
        #1 Enable = 1'b1;
        repeat (10) @(posedge Clk);
        #1 Enable = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            chk("disabled_valid",       32'(bus.ResultValid), 0);
            chk("disabled_keep_period", 32'(bus.Period),      32'(last_exp.period));
        end
        run_seg(12, 5, 1'b0, 1'b0, 2, 1'b0);

        for (int n = 0; n < 8; n++) begin
            p = $urandom_range(4, 16);
            h = $urandom_range(1, p - 1);
            run_seg(p, h, 1'b0, 1'b0, 2, 1'b0);
        end

        // Reset while a result is held.
        mon_on = 1'b0;
        gen_const = 1'b0;
        gen_p = 6;
        gen_h = 3;
        repeat (20) @(posedge Clk);
        #1 Enable = 1'b1;
        guard = 0;
        @(negedge Clk);
        while (!bus.ResultValid && guard < 200) begin
            @(negedge Clk);
            guard++;
        end
        chk("hold_before_reset_valid",  32'(bus.ResultValid), 1);
        chk("hold_before_reset_period", 32'(bus.Period),      6);
        #2 Reset = 1'b0;
        #1;
        chk("async_reset_valid",    32'(bus.ResultValid), 0);
        chk("async_reset_period",   32'(bus.Period),      0);
        chk("async_reset_hightime", 32'(bus.HighTime),    0);
        chk("async_reset_stuck",    32'(bus.Stuck),       0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/clock_period_meter.md
Name: clock_period_meter

Overview:
- Downstream consumer of the frequency divider's ClkOut. Treats ClkOut as data, measures its period and high time in Clk cycles, and flags a stalled divider output.
- Delivers each measurement over a valid/ready handshake to the status/register stage. Used for divider self-check and Din-to-frequency calibration.

Parameters:
- WIDTH, 32, width of the period/high-time counters and result outputs.
- SYNC_STAGES, 2, synchronizer flops on SigIn (minimum 2).
- TIMEOUT, 65535, Clk cycles without a rising edge before a stall is declared. Must be ≤ 2^WIDTH-1 and ≥ 4.

Ports:
- Clk  input  1  single system clock; all state on posedge Clk.
- Reset  input  1  reset; one clock, reset is asynchronous and active-low.
- Enable  input  1  measurement enable; low forces IDLE synchronously.
- SigIn  input  1  signal under measurement (divider ClkOut), asynchronous to logic.
- Period  output  WIDTH  Clk cycles between consecutive rising edges; 0 on stall.
- HighTime  output  WIDTH  Clk cycles SigIn was sampled high within Period; 0 on stall.
- Stuck  output  1  result is a timeout, not a measurement.
- StuckLevel  output  1  synchronized SigIn level when the timeout fired.
- ResultValid  output  1  result fields valid.
- ResultReady  input  1  consumer accepts the result.

Behaviour:
- Reset low (asynchronous): all outputs 0, all synchronizer flops 0, counters 0, edge-detect history 0, state IDLE.
- Synchronizer: SYNC_STAGES flops produce sync. prev is sync delayed one cycle. Rising edge is rise = sync & ~prev.
- Latency: a SigIn transition appears at rise SYNC_STAGES+1 cycles later.
- Resolution: SigIn faster than Clk/2, e.g. a divide-by-1 bypass, cannot be measured. The result is undefined but the block must not hang, because the timeout still applies.
- FSM states: IDLE, ARM, MEAS, HOLD.
- IDLE:
  - ResultValid = 0.
  - Go to ARM when Enable = 1. Clear Cnt and HighCnt.
- ARM (waiting for the first edge):
  - Cnt increments each cycle.
  - On rise: Cnt <= 1, HighCnt <= 1, go to MEAS.
  - If no rise and Cnt reaches TIMEOUT: stall capture.
- MEAS (measuring):
  - On a cycle without rise: Cnt <= Cnt+1, HighCnt <= HighCnt + sync.
  - On rise: Period <= Cnt, HighTime <= HighCnt, Stuck <= 0, ResultValid <= 1, go to HOLD.
- Stall capture (from ARM or MEAS, when Cnt == TIMEOUT and no rise on that cycle):
  - Period <= 0, HighTime <= 0, Stuck <= 1, StuckLevel <= sync, ResultValid <= 1.
  - Go to HOLD.
- Rise and timeout on the same cycle: rise wins.
- HOLD:
  - Result fields and ResultValid stay stable until ResultValid & ResultReady on a rising Clk edge.
  - Next cycle: ResultValid = 0, Cnt = 0, state ARM.
  - Edges during HOLD are ignored. Back-to-back results therefore cover alternate periods, which is acceptable.
- ResultReady high while ResultValid is low has no effect.
- Enable low in any state: next cycle the state is IDLE and ResultValid = 0. Period, HighTime, Stuck and StuckLevel keep their last values. The synchronizer keeps running.
- Enable high again: restart from ARM via IDLE, so no partial period is ever reported.
- Counters never wrap: Cnt ≤ TIMEOUT ≤ 2^WIDTH-1, and HighCnt ≤ Cnt.

Test Plan:
- Reset release, Enable=1, SigIn driven high 2 / low 2 Clk cycles repeatedly. Required: first ResultValid with Period=4, HighTime=2, Stuck=0.
- SigIn high 3 / low 7, ResultReady held low 20 cycles, then pulsed for 1 cycle. Required: Period=10, HighTime=3 stable for the whole hold; ResultValid falls on the cycle after the handshake; a new result follows.
- TIMEOUT=16, SigIn held at 1. Required: ResultValid with Period=0, HighTime=0, Stuck=1, StuckLevel=1 at 16 cycles after ARM entry. Repeat with SigIn=0, which requires StuckLevel=0.
- SigIn period 16, rise coinciding with Cnt==TIMEOUT (TIMEOUT=16). Required: normal result Period=16, Stuck=0.
- Enable dropped mid-MEAS, then raised again. Required:
  - ResultValid=0 and the previous Period is retained while Enable is low.
  - After re-enable, the first result is a full period (no truncated value).
- Reset asserted low during HOLD. Required: ResultValid, Period, HighTime and Stuck are 0 immediately, without a clock edge.
